// File: rtl/memory_mutator_pkg.sv
// Shared types for the memory-stage bus sequencer: FSM states and access-size encodings.
package memory_mutator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/memory_mutator_align.sv
// Combinational lane steering: store shift, load extraction/extension, misalignment detect.
module memory_mutator_align
  import memory_mutator_pkg::*;
(
  input  logic [1:0]  access_size,
  input  logic [1:0]  offset,
  input  logic        sign,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic        misaligned,
  output logic [3:0]  lane_be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = bus_rdata >> {offset, 3'b000};
    lane_be    = byte_en << offset;
    lane_wdata = wdata << {offset, 3'b000};
    misaligned = 1'b0;
    load_data  = shifted;
    case (access_size)
      SIZE_BYTE: load_data = {{24{sign & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: begin
        misaligned = offset[0];
        load_data  = {{16{sign & shifted[15]}}, shifted[15:0]};
      end
      SIZE_WORD: misaligned = |offset;
      default:   misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/memory_mutator_bus.sv
// Memory-stage bus sequencer: one req/ack transaction per latched access descriptor.
// Optional BUSY watchdog enabled with `define MEM_MUTATOR_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for a nonzero byte_en
//   BUSY  | bus_req held until bus_ack (or watchdog expiry)
//   DONE  | one-cycle completion; pipeline released, start ignored
module memory_mutator_bus
  import memory_mutator_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rw,
  input  logic              sign,
  input  logic [3:0]        byte_en,
  input  logic [1:0]        access_size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d, rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d, fault_q, fault_d;
  logic              start, bus_clr, misaligned;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata, load_data;
  logic [15:0]       cnt_q, cnt_d;

  assign start = |byte_en;

  memory_mutator_align u_align (
    .access_size (access_size),
    .offset      (addr[1:0]),
    .sign        (sign),
    .byte_en     (byte_en),
    .wdata       (wdata),
    .bus_rdata   (bus_rdata),
    .misaligned  (misaligned),
    .lane_be     (lane_be),
    .lane_wdata  (lane_wdata),
    .load_data   (load_data)
  );

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    fault_d       = 1'b0;
    cnt_d         = cnt_q;
    bus_clr       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (misaligned) begin
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          bus_req_d   = 1'b1;
          bus_we_d    = rw;
          bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          bus_be_d    = lane_be;
          bus_wdata_d = lane_wdata;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          bus_clr = 1'b1;
          state_d = DONE;
          if (!bus_we_q) begin
            rdata_d       = load_data;
            rdata_valid_d = 1'b1;
          end
        end
`ifdef MEM_MUTATOR_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          bus_clr = 1'b1;
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus_clr) begin
      bus_req_d   = 1'b0;
      bus_we_d    = 1'b0;
      bus_addr_d  = '0;
      bus_be_d    = '0;
      bus_wdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      fault_q       <= fault_d;
      cnt_q         <= cnt_d;
    end
  end

`ifndef MEM_MUTATOR_TIMEOUT_EN
  // Watchdog absent: the counter never leaves zero and the limit is not consulted.
  logic unused_timeout;
  assign unused_timeout = ^{TO_LAST, cnt_q};
`endif

  // Reset forces stall low even while upstream still presents the aborted access.
  assign stall       = ~rst & (((state_q == IDLE) & start) | (state_q == BUSY));
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign fault       = fault_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;

endmodule

// File: doc/memory_mutator_bus.md
# memory_mutator_bus

Memory-stage bus sequencer sitting directly downstream of the memory-mutator control latch. Accepts the latched access descriptor (rw, sign, byte_en, access_size) with address and store data, checks alignment, and runs one request/acknowledge transaction on the data bus. It lane-shifts store data, extracts and sign/zero-extends load data, and stalls the pipeline until the access completes.

## Interface
- ADDR_W, 32, address width
- TIMEOUT, 255, max BUSY cycles without bus_ack before fault (1..65535)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rw  in  1  1 = store, 0 = load
- sign  in  1  1 = sign-extend load result
- byte_en  in  4  lane-0 byte mask; access present when nonzero
- access_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- addr  in  ADDR_W  byte address
- wdata  in  32  store value, right-justified
- stall  out  1  hold upstream latch and pipeline
- rdata  out  32  aligned/extended load result
- rdata_valid  out  1  one-cycle load-complete pulse
- fault  out  1  one-cycle misalign/illegal/timeout pulse
- bus_req, bus_we  out  1  request, write enable
- bus_addr  out  ADDR_W  word address (addr with [1:0] = 0)
- bus_be  out  4  lane byte enables
- bus_wdata  out  32  lane-shifted store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  transaction complete

## Operation
- start = |byte_en. Inputs held stable by upstream while stall = 1.
- States IDLE, BUSY, DONE.
- IDLE, start, aligned: register bus_addr, bus_we = rw, bus_be = (byte_en << addr[1:0]) truncated to 4 bits, bus_wdata = wdata << 8*addr[1:0]; go BUSY.
- IDLE, start, misaligned (half with addr[0] = 1, word with addr[1:0] != 0, or access_size 11): no bus activity; go DONE with fault = 1.
- BUSY: bus_req = 1 until the bus_ack cycle. On bus_ack, load: rdata = extend(bus_rdata >> 8*addr[1:0]), 8-bit for byte, 16-bit for half, unmodified for word; sign selects sign vs zero extension. Go DONE.
- DONE: one cycle, stall = 0; rdata_valid = 1 for completed loads only; start ignored (inputs still hold the finished access); go IDLE.
- stall = (IDLE & start) | BUSY, combinational.
- Reset values: all outputs 0, state IDLE, timeout counter 0. Reset during BUSY drops bus_req immediately; no completion or fault reported.
- bus_ack outside BUSY is ignored.
- rdata holds its value until the next load completes; stores do not change it.

## Timing
- Minimum access: start cycle (IDLE), one BUSY cycle with bus_ack, DONE cycle. rdata_valid asserts 2 cycles after start with zero wait states.
- Each wait state adds one BUSY cycle.
- bus_* outputs registered; stable for the whole BUSY state; deasserted in DONE.
- Misaligned access: fault asserts in the cycle after start; stall high for one cycle only.

## Configuration
- MEM_MUTATOR_TIMEOUT_EN defined: a BUSY cycle counter, cleared on BUSY entry, is included. When TIMEOUT BUSY cycles pass without bus_ack, the block drops bus_req, pulses fault in DONE, and leaves rdata unchanged.
- Undefined: no counter; BUSY waits indefinitely for bus_ack; fault reports misalignment only.

## Structure
- memory_mutator_pkg: state enum (IDLE/BUSY/DONE) and access_size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD.
- Sub-module memory_mutator_align: combinational store lane shift, load extraction and extension, and misalignment detection; instantiated once.

## Test plan
- Load byte, addr 0x1003, sign = 1, bus_rdata 0x80FF_FF00, ack in the first BUSY cycle -> bus_be 4'b1000, rdata 0xFFFF_FF80, rdata_valid 2 cycles after start.
- Store half, addr 0x2002, wdata 0x0000_BEEF, ack after 3 wait states -> bus_we = 1, bus_be 4'b1100, bus_wdata 0xBEEF_0000, stall high 5 cycles, no rdata_valid.
- Load word, addr 0x3001 -> no bus_req, fault pulse next cycle, stall high 1 cycle.
- Load half unsigned, addr 0x4002, bus_rdata 0x8001_0000 -> rdata 0x0000_8001; a following access presented during DONE starts only after the DONE cycle.
- With MEM_MUTATOR_TIMEOUT_EN and TIMEOUT = 4, never ack -> bus_req drops after 4 BUSY cycles, fault pulses, rdata unchanged.
- rst asserted mid-BUSY -> bus_req, stall and fault are 0 immediately; a new access after reset completes normally.
